// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the associative data cache: the controller state
// encoding and helpers that derive the address-field widths from the cache
// geometry parameters.
// ---------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  // Byte-offset field width.
  function automatic int off_w_f(input int block_bytes);
    return $clog2(block_bytes);
  endfunction

  // Set-index field width.
  function automatic int idx_w_f(input int sets);
    return $clog2(sets);
  endfunction

  // Tag field width: whatever is left of the byte address.
  function automatic int tag_w_f(input int addr_w, input int block_bytes, input int sets);
    return addr_w - off_w_f(block_bytes) - idx_w_f(sets);
  endfunction

endpackage

// File: rtl/cache_way.sv
// ---------------------------------------------------------------------------
// cache_way
// Storage for one way of the cache: per-set data block, tag, valid and dirty.
// Lookup is combinational so the controller can answer a hit in the same cycle.
// Ports:
//   CLK, RESET      clock, asynchronous active-low reset (clears valid/dirty)
//   i_index/i_tag/i_offset  decoded CPU address fields
//   i_byte_we/i_byte_data   store one byte into the addressed block, mark dirty
//   i_fill_we/i_fill_data   load a whole block + tag, mark valid and clean
//   o_hit, o_valid, o_dirty status of the addressed set in this way
//   o_byte, o_block, o_tag  addressed byte, whole block and stored tag
// ---------------------------------------------------------------------------
module cache_way
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int SETS        = 8,
  localparam int OFF_W = off_w_f(BLOCK_BYTES),
  localparam int IDX_W = idx_w_f(SETS),
  localparam int TAG_W = tag_w_f(ADDR_W, BLOCK_BYTES, SETS),
  localparam int BLK_W = BLOCK_BYTES * 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [IDX_W-1:0] i_index,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [OFF_W-1:0] i_offset,
  input  logic             i_byte_we,
  input  logic [7:0]       i_byte_data,
  input  logic             i_fill_we,
  input  logic [BLK_W-1:0] i_fill_data,
  output logic             o_hit,
  output logic             o_valid,
  output logic             o_dirty,
  output logic [7:0]       o_byte,
  output logic [BLK_W-1:0] o_block,
  output logic [TAG_W-1:0] o_tag
);

  logic [BLK_W-1:0] r_data [SETS];
  logic [TAG_W-1:0] r_tag  [SETS];
  logic [SETS-1:0]  r_valid;
  logic [SETS-1:0]  r_dirty;

  // Data and tags need no reset: nothing is visible until valid is set.
  // Fill (UPDATE) and byte store (IDLE hit) never coincide.
  always_ff @(posedge CLK) begin
    if (i_fill_we) begin
      r_data[i_index] <= i_fill_data;
      r_tag[i_index]  <= i_tag;
    end else if (i_byte_we) begin
      r_data[i_index][{i_offset, 3'b000} +: 8] <= i_byte_data;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_index] <= 1'b1;
      r_dirty[i_index] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_index] <= 1'b1;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_dirty = r_dirty[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_block = r_data[i_index];
  assign o_hit   = o_valid && (o_tag == i_tag);
  assign o_byte  = o_block[{i_offset, 3'b000} +: 8];

endmodule

// File: rtl/assoc_dcache.sv
// ---------------------------------------------------------------------------
// assoc_dcache
// Write-back, write-allocate data cache (1 or 2 ways, true LRU) between the
// CPU byte load/store port and a block-wide memory, with saturating hit/miss
// statistics.
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   read, write           CPU requests, held until busywait is low
//   address, writedata    CPU byte address and store data
//   readdata, busywait    load data (combinational on hit), CPU stall
//   mem_read, mem_write   block fetch / write-back requests (registered)
//   mem_address           block address {tag, index}
//   mem_writedata         victim block on write-back
//   mem_readdata          fetched block
//   mem_busywait          memory busy; a low cycle completes the request
//   hit_count, miss_count saturating statistics
// ---------------------------------------------------------------------------
module assoc_dcache
  import cache_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int BLOCK_BYTES = 4,
  parameter int SETS        = 8,
  parameter int WAYS        = 2,
  parameter int CNT_W       = 16,
  localparam int OFF_W = off_w_f(BLOCK_BYTES),
  localparam int IDX_W = idx_w_f(SETS),
  localparam int TAG_W = tag_w_f(ADDR_W, BLOCK_BYTES, SETS),
  localparam int MA_W  = ADDR_W - OFF_W,
  localparam int BLK_W = BLOCK_BYTES * 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [MA_W-1:0]   mem_address,
  output logic [BLK_W-1:0]  mem_writedata,
  input  logic [BLK_W-1:0]  mem_readdata,
  input  logic              mem_busywait,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  logic [OFF_W-1:0] w_offset;
  logic [IDX_W-1:0] w_index;
  logic [TAG_W-1:0] w_tag;
  assign w_offset = address[OFF_W-1:0];
  assign w_index  = address[OFF_W +: IDX_W];
  assign w_tag    = address[ADDR_W-1 -: TAG_W];

  state_t           r_state;
  state_t           w_state_next;
  logic             r_from_update;
  logic             r_mem_read;
  logic             r_mem_write;
  logic             r_victim;
  logic [BLK_W-1:0] r_fill;
  logic [SETS-1:0]  r_lru;        // per set: index of the least recently used way
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic [WAYS-1:0]  w_way_hit, w_way_valid, w_way_dirty, w_byte_we, w_fill_we;
  logic [7:0]       w_way_byte  [WAYS];
  logic [BLK_W-1:0] w_way_block [WAYS];
  logic [TAG_W-1:0] w_way_tag   [WAYS];

  logic       w_req, w_hit, w_hit_idx, w_victim, w_hit_edge, w_miss_edge;
  logic [7:0] w_rdata;

  for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
    assign w_byte_we[gi] = (r_state == IDLE) && write && w_way_hit[gi];
    assign w_fill_we[gi] = (r_state == UPDATE) && (r_victim == 1'(gi));

    cache_way #(
      .ADDR_W(ADDR_W), .BLOCK_BYTES(BLOCK_BYTES), .SETS(SETS)
    ) u_way (
      .CLK        (CLK),
      .RESET      (RESET),
      .i_index    (w_index),
      .i_tag      (w_tag),
      .i_offset   (w_offset),
      .i_byte_we  (w_byte_we[gi]),
      .i_byte_data(writedata),
      .i_fill_we  (w_fill_we[gi]),
      .i_fill_data(r_fill),
      .o_hit      (w_way_hit[gi]),
      .o_valid    (w_way_valid[gi]),
      .o_dirty    (w_way_dirty[gi]),
      .o_byte     (w_way_byte[gi]),
      .o_block    (w_way_block[gi]),
      .o_tag      (w_way_tag[gi])
    );
  end

  assign w_req       = read | write;
  assign w_hit       = |w_way_hit;
  assign w_hit_edge  = (r_state == IDLE) && w_req && w_hit;
  assign w_miss_edge = (r_state == IDLE) && w_req && !w_hit;

  // Hit way index and load data; readdata stays 0 when nothing hits.
  always_comb begin
    w_hit_idx = 1'b0;
    w_rdata   = 8'h00;
    for (int w = 0; w < WAYS; w++) begin
      if (w_way_hit[w]) begin
        w_hit_idx = 1'(w);
        w_rdata   = w_way_byte[w];
      end
    end
  end

  // Victim: lowest-index invalid way, else the LRU way (descending scan so
  // the lowest invalid index is the last assignment).
  always_comb begin
    w_victim = (WAYS == 2) ? r_lru[w_index] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!w_way_valid[w]) w_victim = 1'(w);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_miss_edge)
                   w_state_next = (w_way_valid[w_victim] && w_way_dirty[w_victim])
                                  ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (!mem_busywait) w_state_next = ALLOCATE;
      ALLOCATE:  if (!mem_busywait) w_state_next = UPDATE;
      UPDATE:    w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_from_update <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_victim      <= 1'b0;
      r_fill        <= '0;
      r_lru         <= '0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else begin
      // Marks the first IDLE cycle after a fill: that hit is the retry of
      // the request already counted as a miss.
      r_from_update <= (r_state == UPDATE);
      r_mem_read    <= (w_state_next == ALLOCATE);
      r_mem_write   <= (w_state_next == WRITEBACK);
      if (w_miss_edge) r_victim <= w_victim;
      if (r_state == ALLOCATE && !mem_busywait) r_fill <= mem_readdata;
      if (w_hit_edge) r_lru[w_index] <= ~w_hit_idx;
      if (w_hit_edge && !r_from_update && r_hit_cnt != '1)
        r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (w_miss_edge && r_miss_cnt != '1)
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign readdata      = w_rdata;
  assign busywait      = (r_state != IDLE) | (w_req & ~w_hit);
  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = (r_state == WRITEBACK) ? {w_way_tag[r_victim], w_index}
                                                : {w_tag, w_index};
  assign mem_writedata = w_way_block[r_victim];
  assign hit_count     = r_hit_cnt;
  assign miss_count    = r_miss_cnt;

endmodule

// File: tb/tb_assoc_dcache.sv
// ---------------------------------------------------------------------------
// tb_assoc_dcache
// Scoreboard bench: each CPU access pushes the expected load value, computed
// from a flat byte-memory reference and a 2-entry recency list per set; a
// monitor pops and compares whenever the cache completes a request.
// ---------------------------------------------------------------------------
module tb_assoc_dcache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        read_s, write_s;
  logic [7:0]  addr_s, wdata_s;
  logic [7:0]  readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;
  logic [15:0] hit_count, miss_count;

  // secondary instances (WAYS=1, CNT_W=4), read-only with a zero-latency memory
  logic        rq_w1, rq_c4;
  logic [7:0]  addr_x;
  logic [7:0]  rd_w1, rd_c4;
  logic        busy_w1, busy_c4, mr_w1, mw_w1, mr_c4, mw_c4;
  logic [5:0]  ma_w1, ma_c4;
  logic [31:0] mwd_w1, mwd_c4;
  logic [15:0] hit_w1, miss_w1;
  logic [3:0]  hit_c4, miss_c4;

  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] pat_byte(input int a);
    return 8'(((a >> 2) + (a & 3)) * 17);
  endfunction

  function automatic logic [31:0] pat_block(input int n);
    logic [31:0] b;
    for (int k = 0; k < 4; k++) b[8*k +: 8] = pat_byte(n * 4 + k);
    return b;
  endfunction

  assoc_dcache u_dut (
    .CLK(clk), .RESET(rst_n), .read(read_s), .write(write_s), .address(addr_s),
    .writedata(wdata_s), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_busywait(mem_busywait), .hit_count(hit_count), .miss_count(miss_count)
  );

  assoc_dcache #(.WAYS(1)) u_w1 (
    .CLK(clk), .RESET(rst_n), .read(rq_w1), .write(1'b0), .address(addr_x),
    .writedata(8'h00), .readdata(rd_w1), .busywait(busy_w1),
    .mem_read(mr_w1), .mem_write(mw_w1), .mem_address(ma_w1),
    .mem_writedata(mwd_w1), .mem_readdata(pat_block(int'(ma_w1))),
    .mem_busywait(1'b0), .hit_count(hit_w1), .miss_count(miss_w1)
  );

  assoc_dcache #(.CNT_W(4)) u_c4 (
    .CLK(clk), .RESET(rst_n), .read(rq_c4), .write(1'b0), .address(addr_x),
    .writedata(8'h00), .readdata(rd_c4), .busywait(busy_c4),
    .mem_read(mr_c4), .mem_write(mw_c4), .mem_address(ma_c4),
    .mem_writedata(mwd_c4), .mem_readdata(pat_block(int'(ma_c4))),
    .mem_busywait(1'b0), .hit_count(hit_c4), .miss_count(miss_c4)
  );

  // ---------------- block memory with random latency ----------------------
  typedef struct { logic wr; logic [5:0] addr; logic [31:0] data; } mlog_t;
  mlog_t mlog[$];
  logic [31:0] mem [64];
  int lat_cnt = 0;
  int lat_tgt = 1;

  assign mem_busywait = (mem_read | mem_write) && (lat_cnt != lat_tgt);
  assign mem_readdata = mem[mem_address];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat_block(i);
      lat_cnt <= 0;
      lat_tgt <= 1;
    end else if (mem_read | mem_write) begin
      if (lat_cnt == lat_tgt) begin
        lat_cnt <= 0;
        lat_tgt <= int'($urandom_range(0, 3));
        mlog.push_back('{wr: mem_write, addr: mem_address, data: mem_writedata});
        if (mem_write) mem[mem_address] <= mem_writedata;
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  // ---------------- checking ----------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct { bit rd; logic [7:0] a; logic [7:0] v; } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (rst_n && (read_s || write_s) && !busywait) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got completion at %02h expected none", addr_s);
      end else begin
        if (exp_q[0].rd) chk($sformatf("load_%02h", exp_q[0].a), 32'(readdata), 32'(exp_q[0].v));
        void'(exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (mem_read || mem_write))
      chk("mem_excl", 32'(mem_read & mem_write), 32'd0);
  end

  // ---------------- reference model ----------------------------------------
  logic [7:0] ref_mem [256];
  int mru [8];
  int lru [8];
  int exp_hit, exp_miss, n_txn = 0;

  task automatic do_reset();
    rst_n = 1'b0; read_s = 1'b0; write_s = 1'b0; rq_w1 = 1'b0; rq_c4 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int a = 0; a < 256; a++) ref_mem[a] = pat_byte(a);
    for (int s = 0; s < 8; s++) begin mru[s] = -1; lru[s] = -1; end
    exp_hit = 0; exp_miss = 0;
    exp_q.delete();
  endtask

  task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        output bit first_busy);
    int s, t;
    bit done;
    s = (int'(a) >> 2) & 7;
    t = int'(a) >> 5;
    if (mru[s] == t) exp_hit++;
    else begin
      if (lru[s] == t) exp_hit++; else exp_miss++;
      lru[s] = mru[s];
      mru[s] = t;
    end
    exp_q.push_back('{rd: !wr, a: a, v: ref_mem[a]});
    if (wr) ref_mem[a] = d;
    write_s = wr; read_s = !wr; addr_s = a; wdata_s = d;
    first_busy = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (i == 0) first_busy = busywait;
      if (!busywait) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL access_timeout: got busywait=1 at %02h expected completion", a);
    end
    n_txn++;
    $display("txn %0d %s addr=%02h data=%02h first_busy=%0b", n_txn, wr ? "W" : "R",
             a, wr ? d : readdata, first_busy);
    @(posedge clk);
    #1 read_s = 1'b0; write_s = 1'b0;
  endtask

  task automatic access_x(input int which, input logic [7:0] a);
    bit done = 1'b0;
    addr_x = a;
    if (which == 0) rq_w1 = 1'b1; else rq_c4 = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (!((which == 0) ? busy_w1 : busy_c4)) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL accx_timeout: got busywait=1 on inst %0d expected completion", which);
    end
    n_txn++;
    $display("txn %0d R inst%0d addr=%02h data=%02h", n_txn, which, a,
             (which == 0) ? rd_w1 : rd_c4);
    @(posedge clk);
    #1 rq_w1 = 1'b0; rq_c4 = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------------------------------------
  initial begin
    bit fb;
    int s0;
    rst_n = 1'b1; read_s = 1'b0; write_s = 1'b0; addr_s = 8'h00; wdata_s = 8'h00;
    rq_w1 = 1'b0; rq_c4 = 1'b0; addr_x = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busywait), 0);
    chk("rst_mrd", 32'(mem_read), 0);
    chk("rst_mwr", 32'(mem_write), 0);
    chk("rst_rdata", 32'(readdata), 0);
    chk("rst_hits", 32'(hit_count), 0);
    chk("rst_miss", 32'(miss_count), 0);
    do_reset();

    // cold miss then hit in the same block
    s0 = mlog.size();
    access(1'b0, 8'h05, 8'h00, fb);
    chk("cold_busy", 32'(fb), 1);
    chk("cold_nmem", 32'(mlog.size() - s0), 1);
    if (mlog.size() > s0) begin
      chk("cold_kind", 32'(mlog[s0].wr), 0);
      chk("cold_maddr", 32'(mlog[s0].addr), 32'h01);
    end
    chk("cold_miss", 32'(miss_count), 1);
    chk("cold_hit", 32'(hit_count), 0);
    access(1'b0, 8'h06, 8'h00, fb);
    chk("hit_busy", 32'(fb), 0);
    chk("hit_cnt", 32'(hit_count), 1);

    // dirty eviction
    do_reset();
    access(1'b1, 8'h00, 8'hAA, fb);
    access(1'b1, 8'h20, 8'hBB, fb);
    access(1'b0, 8'h00, 8'h00, fb);
    s0 = mlog.size();
    access(1'b0, 8'h40, 8'h00, fb);
    chk("evict_nmem", 32'(mlog.size() - s0), 2);
    if (mlog.size() > s0 + 1) begin
      chk("evict_kind0", 32'(mlog[s0].wr), 1);
      chk("evict_addr0", 32'(mlog[s0].addr), 32'h08);
      chk("evict_data0", 32'(mlog[s0].data[7:0]), 32'hBB);
      chk("evict_kind1", 32'(mlog[s0+1].wr), 0);
      chk("evict_addr1", 32'(mlog[s0+1].addr), 32'h10);
    end
    chk("evict_miss", 32'(miss_count), 3);
    access(1'b0, 8'h20, 8'h00, fb);   // written-back byte must come back

    // clean eviction
    do_reset();
    access(1'b0, 8'h00, 8'h00, fb);
    access(1'b0, 8'h20, 8'h00, fb);
    s0 = mlog.size();
    access(1'b0, 8'h40, 8'h00, fb);
    chk("clean_nmem", 32'(mlog.size() - s0), 1);
    if (mlog.size() > s0) begin
      chk("clean_kind", 32'(mlog[s0].wr), 0);
      chk("clean_addr", 32'(mlog[s0].addr), 32'h10);
    end

    // reset in the middle of ALLOCATE
    do_reset();
    addr_s = 8'h00; read_s = 1'b1;
    for (int i = 0; i < 10 && !mem_read; i++) begin @(posedge clk); #1; end
    chk("mid_mrd_before", 32'(mem_read), 1);
    rst_n = 1'b0; read_s = 1'b0;
    #1;
    chk("mid_mrd", 32'(mem_read), 0);
    chk("mid_busy", 32'(busywait), 0);
    chk("mid_miss", 32'(miss_count), 0);
    chk("mid_hit", 32'(hit_count), 0);
    do_reset();
    access(1'b0, 8'h00, 8'h00, fb);
    chk("post_rst_busy", 32'(fb), 1);
    chk("post_rst_miss", 32'(miss_count), 1);

    // randomized mix concentrated on two sets to force evictions
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [7:0] a;
      a = 8'(($urandom_range(0, 7) << 5) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3));
      access($urandom_range(0, 2) == 0, a, 8'($urandom), fb);
    end
    chk("rand_hits", 32'(hit_count), 32'(exp_hit));
    chk("rand_miss", 32'(miss_count), 32'(exp_miss));

    // direct-mapped instance thrashing, then 4-bit counter saturation
    do_reset();
    for (int i = 0; i < 6; i++) access_x(0, (i % 2 == 1) ? 8'h20 : 8'h00);
    chk("w1_miss", 32'(miss_w1), 6);
    chk("w1_hit", 32'(hit_w1), 0);
    access_x(1, 8'h00);
    for (int i = 0; i < 20; i++) access_x(1, 8'h00);
    chk("c4_hit", 32'(hit_c4), 15);
    chk("c4_miss", 32'(miss_c4), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/assoc_dcache.md
Name: assoc_dcache

Overview:
Parametrised write-back, write-allocate data cache between the CPU load/store port and the block-wide data memory. It is the successor of the current direct-mapped data cache and keeps the same CPU-side busywait handshake. It adds configurable sets, ways (1 or 2), block size, true-LRU replacement and saturating hit/miss counters. It sits in the CPU top-level in place of the existing data cache.

Parameters:
ADDR_W, 8, CPU byte-address width.
BLOCK_BYTES, 4, bytes per block (power of 2); memory data width = BLOCK_BYTES*8.
SETS, 8, number of sets (power of 2).
WAYS, 2, associativity; legal values 1 or 2.
CNT_W, 16, width of each statistics counter.

Ports:
CLK  in  1  clock, rising-edge.
RESET  in  1  asynchronous, active-low reset.
read  in  1  CPU load request, level held until busywait low.
write  in  1  CPU store request, level held until busywait low.
address  in  ADDR_W  CPU byte address.
writedata  in  8  store data.
readdata  out  8  load data.
busywait  out  1  CPU stall.
mem_read  out  1  block fetch request.
mem_write  out  1  block write-back request.
mem_address  out  ADDR_W-log2(BLOCK_BYTES)  block address.
mem_writedata  out  BLOCK_BYTES*8  victim block.
mem_readdata  in  BLOCK_BYTES*8  fetched block.
mem_busywait  in  1  memory busy; low for one cycle marks completion.
hit_count  out  CNT_W  accesses that hit on first presentation.
miss_count  out  CNT_W  accesses that missed.

Behaviour:
- Address split: offset = low log2(BLOCK_BYTES) bits; index = next log2(SETS) bits; tag = remaining bits.
- Reset (RESET=0, asynchronous):
  - all valid, dirty and LRU bits cleared; state=IDLE.
  - mem_read=0, mem_write=0, busywait=0, readdata=0, counters=0.
  - Applies at any point, including mid-WRITEBACK or mid-ALLOCATE; the memory request drops immediately.
- Hit (IDLE, tag match in a valid way):
  - busywait=0; readdata is combinational from the hit way.
  - A write hit updates the byte and sets dirty at the next rising edge.
  - The hit way becomes MRU.
- Miss: busywait=1 combinationally in the same cycle. FSM states IDLE, WRITEBACK, ALLOCATE, UPDATE.
  - IDLE->WRITEBACK if victim valid and dirty, else IDLE->ALLOCATE; miss_count++ on this edge.
  - WRITEBACK: mem_write=1, mem_address={victim tag, index}, mem_writedata=victim block. Go to ALLOCATE on an edge where mem_busywait=0.
  - ALLOCATE: mem_read=1, mem_address={tag, index}. Go to UPDATE on an edge where mem_busywait=0.
  - UPDATE: latch mem_readdata into the victim way; set valid, clear dirty, tag=new. busywait stays 1. Go to IDLE.
  - In IDLE the held request now hits and completes. This retry is not counted as a hit.
- Victim selection: the lowest-index invalid way first, otherwise the LRU way. With WAYS=1 the LRU bit is unused.
- busywait = (state!=IDLE) | ((read|write) & ~hit).
- read and write both high: write takes precedence.
- Counters saturate at 2^CNT_W-1 and never wrap. hit_count++ on an IDLE hit edge unless the previous state was UPDATE.
- mem_read and mem_write are never high together; both are registered from state.

Decomposition:
- Shared package cache_pkg holds:
  - the state encoding constants (IDLE=0, WRITEBACK=1, ALLOCATE=2, UPDATE=3);
  - the derived widths OFF_W, IDX_W, TAG_W as functions of the parameters.
- One sub-module, cache_way: the data/tag/valid/dirty storage for one way.
  - Inputs: index, tag, write-enable paths.
  - Outputs: hit, selected byte, full block, tag.
  - Instantiated WAYS times.
- The LRU bits and the FSM remain in assoc_dcache.

Test Plan:
All scenarios use SETS=8, WAYS=2, BLOCK_BYTES=4 (3-bit tag, 3-bit index, 2-bit offset) and memory block n preset to {n+3,n+2,n+1,n}*0x11 pattern, unless stated otherwise.
- Cold read 0x05 -> busywait=1, mem_read=1, mem_address=0x01; after completion readdata=0x22, miss_count=1, hit_count=0. Then read 0x06 -> busywait=0 same cycle, readdata=0x33, hit_count=1.
- Dirty eviction:
  - Stimulus: write 0x00=0xAA, write 0x20=0xBB, read 0x00, read 0x40.
  - Final miss evicts way holding tag 1: mem_write=1 with mem_address=0x08 and mem_writedata[7:0]=0xBB.
  - Then mem_read with mem_address=0x10; miss_count=3.
- Clean eviction: reads 0x00, 0x20, 0x40 -> the third miss issues mem_read only, no mem_write cycle.
- Reset mid-operation: RESET=0 during ALLOCATE -> mem_read=0, busywait=0 and counters=0 immediately. After release, read 0x00 misses again.
- WAYS=1 instance: alternate reads 0x00/0x20 six times -> six misses, zero hits.
- CNT_W=4 instance: 20 consecutive read hits -> hit_count saturates at 15.
